// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register file write port
// between the ALU (port 0, high priority) and the load/store unit
// (port 1), and tracks pending writes for decode's RAW stall logic.
//
// Ports:
//   clk, rst        clock (rising edge), async active-low reset
//   v0/a0/d0/r0     port 0 request valid / dest / data / accepted
//   v1/a1/d1/r1     port 1 request valid / dest / data / accepted
//   iss_valid/addr  decode issued an instruction writing iss_addr
//   busy            scoreboard, bit i = write to xi pending
//   we/wa/wn        registered register file write port
//
// Optional: define WBARB_STARVE_GUARD_EN to force-grant port 1
// after it has lost arbitration MAX_WAIT cycles in a row.

module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        v0,
  input  logic [4:0]  a0,
  input  logic [31:0] d0,
  output logic        r0,
  input  logic        v1,
  input  logic [4:0]  a1,
  input  logic [31:0] d1,
  output logic        r1,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  output logic [31:0] busy,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wn
);

  if ((2 ** CNT_W) <= MAX_WAIT) begin : g_bad_cnt_w
    $error("CNT_W too narrow for MAX_WAIT");
  end

  logic        t0;
  logic        t1;
  logic        xfer;
  logic [4:0]  xa;
  logic [31:0] xd;
  logic [31:0] busy_n;

`ifdef WBARB_STARVE_GUARD_EN
  localparam logic [CNT_W-1:0] MAXC =
    CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt;
  logic             force1;

  // Port 1 has waited long enough: it takes
  // this cycle even though port 0 is asking.
  assign force1 = v1 & (cnt == MAXC);

  assign r0 = v0 & ~force1;
  assign r1 = v1 & (~v0 | force1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!v1 || r1) begin
      cnt <= '0;
    end else if (v0 && cnt != MAXC) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign r0 = v0;
  assign r1 = v1 & ~v0;
`endif

  assign t0   = v0 & r0;
  assign t1   = v1 & r1;
  assign xfer = t0 | t1;

  always_comb begin
    xa = '0;
    xd = '0;
    unique case (1'b1)
      t0: begin
        xa = a0;
        xd = d0;
      end
      t1: begin
        xa = a1;
        xd = d1;
      end
      default: begin
        xa = '0;
        xd = '0;
      end
    endcase
  end

  // Set is applied after clear so a newer
  // producer to the same register wins.
  always_comb begin
    busy_n = busy;
    if (xfer && xa != 5'd0) begin
      busy_n[xa] = 1'b0;
    end
    if (iss_valid && iss_addr != 5'd0) begin
      busy_n[iss_addr] = 1'b1;
    end
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_n;
    end
  end

  // x0 writes are consumed but never reach
  // the port; wa/wn hold their last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we <= 1'b0;
      wa <= '0;
      wn <= '0;
    end else if (xfer && xa != 5'd0) begin
      we <= 1'b1;
      wa <= xa;
      wn <= xd;
    end else begin
      we <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  a_one_grant: assert property (
    @(posedge clk) disable iff (!rst)
    !(r0 && r1)
  );

  a_x0_free: assert property (
    @(posedge clk) disable iff (!rst)
    !busy[0]
  );

  a_idle_ready: assert property (
    @(posedge clk) disable iff (!rst)
    !(v0 || v1) || (r0 || r1)
  );
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench
// for the write-back arbiter and pending-write scoreboard.

module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        v0;
  logic [4:0]  a0;
  logic [31:0] d0;
  logic        r0;
  logic        v1;
  logic [4:0]  a1;
  logic [31:0] d1;
  logic        r1;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [31:0] busy;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wn;

  int n_chk;
  int n_fail;

  regfile_wb_arbiter #(
    .MAX_WAIT(3),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .v0(v0),
    .a0(a0),
    .d0(d0),
    .r0(r0),
    .v1(v1),
    .a1(a1),
    .d1(d1),
    .r1(r1),
    .iss_valid(iss_valid),
    .iss_addr(iss_addr),
    .busy(busy),
    .we(we),
    .wa(wa),
    .wn(wn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    v0 = 1'b0;
    a0 = '0;
    d0 = '0;
    v1 = 1'b0;
    a1 = '0;
    d1 = '0;
    iss_valid = 1'b0;
    iss_addr = '0;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    @(negedge clk);
    v0 = 1'b1;
    a0 = 5'd9;
    d0 = 32'h1111_1111;
    iss_valid = 1'b1;
    iss_addr = 5'd9;
    @(negedge clk);
    idle();
    rst = 1'b1;
    #1;
    n_chk++;
    if ({we, wa, wn} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_port we=%0b wa=%0d wn=%h want 0",
               we, wa, wn);
    end
    n_chk++;
    if (busy !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_busy got %h want 0", busy);
    end
    n_chk++;
    if ({r0, r1} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 00", {r0, r1});
    end
    edge_wait();
    n_chk++;
    if (we !== 1'b0 || busy !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_idle we=%0b busy=%h want 0/0",
               we, busy);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    v0 = 1'b1;
    a0 = 5'd5;
    d0 = 32'hDEAD_BEEF;
    #1;
    n_chk++;
    if ({r0, r1} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_ready got %b want 10", {r0, r1});
    end
    edge_wait();
    n_chk++;
    if ({we, wa, wn} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL single_write we=%0b wa=%0d wn=%h want 1/5/deadbeef",
               we, wa, wn);
    end
    @(negedge clk);
    idle();
    edge_wait();
    n_chk++;
    if (we !== 1'b0 || wa !== 5'd5) begin
      n_fail++;
      $display("FAIL single_drop we=%0b wa=%0d want 0/5", we, wa);
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    v0 = 1'b1;
    a0 = 5'd3;
    d0 = 32'd1;
    v1 = 1'b1;
    a1 = 5'd4;
    d1 = 32'd2;
    #1;
    n_chk++;
    if ({r0, r1} !== 2'b10) begin
      n_fail++;
      $display("FAIL prio_both got %b want 10", {r0, r1});
    end
    edge_wait();
    n_chk++;
    if ({we, wa, wn} !== {1'b1, 5'd3, 32'd1}) begin
      n_fail++;
      $display("FAIL prio_w3 we=%0b wa=%0d wn=%h want 1/3/1",
               we, wa, wn);
    end
    @(negedge clk);
    v0 = 1'b0;
    #1;
    n_chk++;
    if ({r0, r1} !== 2'b01) begin
      n_fail++;
      $display("FAIL prio_p1 got %b want 01", {r0, r1});
    end
    edge_wait();
    n_chk++;
    if ({we, wa, wn} !== {1'b1, 5'd4, 32'd2}) begin
      n_fail++;
      $display("FAIL prio_w4 we=%0b wa=%0d wn=%h want 1/4/2",
               we, wa, wn);
    end
    @(negedge clk);
    idle();
    edge_wait();
    n_chk++;
    if (we !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_idle we=%0b want 0", we);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    iss_valid = 1'b1;
    iss_addr = 5'd7;
    edge_wait();
    n_chk++;
    if (busy !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL sb_set1 got %h want 00000080", busy);
    end
    @(negedge clk);
    idle();
    edge_wait();
    n_chk++;
    if (busy !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL sb_set2 got %h want 00000080", busy);
    end
    @(negedge clk);
    v1 = 1'b1;
    a1 = 5'd7;
    d1 = 32'h77;
    edge_wait();
    n_chk++;
    if (busy !== 32'h0 || we !== 1'b1 || wa !== 5'd7) begin
      n_fail++;
      $display("FAIL sb_clr busy=%h we=%0b wa=%0d want 0/1/7",
               busy, we, wa);
    end
    @(negedge clk);
    idle();
    iss_valid = 1'b1;
    iss_addr = 5'd7;
    edge_wait();
    @(negedge clk);
    idle();
    v1 = 1'b1;
    a1 = 5'd7;
    d1 = 32'h78;
    iss_valid = 1'b1;
    iss_addr = 5'd7;
    edge_wait();
    n_chk++;
    if (busy !== 32'h0000_0080 || we !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_setwins busy=%h we=%0b want 00000080/1",
               busy, we);
    end
    @(negedge clk);
    idle();
    v1 = 1'b1;
    a1 = 5'd7;
    d1 = 32'h79;
    iss_valid = 1'b1;
    iss_addr = 5'd9;
    edge_wait();
    n_chk++;
    if (busy !== 32'h0000_0200) begin
      n_fail++;
      $display("FAIL sb_both got %h want 00000200", busy);
    end
    @(negedge clk);
    idle();
    v0 = 1'b1;
    a0 = 5'd12;
    d0 = 32'hC;
    edge_wait();
    n_chk++;
    if (busy !== 32'h0000_0200 || wa !== 5'd12 || we !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_notbusy busy=%h we=%0b wa=%0d want 00000200/1/12",
               busy, we, wa);
    end
    @(negedge clk);
    idle();
    v0 = 1'b1;
    a0 = 5'd9;
    d0 = 32'h9;
    edge_wait();
    @(negedge clk);
    idle();
    edge_wait();
    n_chk++;
    if (busy !== 32'h0) begin
      n_fail++;
      $display("FAIL sb_drain got %h want 0", busy);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    v0 = 1'b1;
    a0 = 5'd6;
    d0 = 32'h1234;
    edge_wait();
    @(negedge clk);
    v0 = 1'b1;
    a0 = 5'd0;
    d0 = 32'hFFFF_FFFF;
    iss_valid = 1'b1;
    iss_addr = 5'd0;
    #1;
    n_chk++;
    if (r0 !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_ready got %0b want 1", r0);
    end
    edge_wait();
    n_chk++;
    if ({we, wa, wn} !== {1'b0, 5'd6, 32'h1234}) begin
      n_fail++;
      $display("FAIL x0_write we=%0b wa=%0d wn=%h want 0/6/1234",
               we, wa, wn);
    end
    n_chk++;
    if (busy !== 32'h0) begin
      n_fail++;
      $display("FAIL x0_busy got %h want 0", busy);
    end
    @(negedge clk);
    idle();
    edge_wait();
  endtask

  task automatic test_back_to_back();
    logic [4:0] ea;
    @(negedge clk);
    v0 = 1'b1;
    v1 = 1'b1;
    a1 = 5'd20;
    d1 = 32'hA1;
`ifdef WBARB_STARVE_GUARD_EN
    for (int i = 0; i < 5; i++) begin
      a0 = 5'(i + 1);
      d0 = 32'(i + 100);
      #1;
      n_chk++;
      if (i == 3) begin
        if ({r0, r1} !== 2'b01) begin
          n_fail++;
          $display("FAIL guard_force cyc=%0d got %b want 01",
                   i, {r0, r1});
        end
      end else if ({r0, r1} !== 2'b10) begin
        n_fail++;
        $display("FAIL guard_wait cyc=%0d got %b want 10",
                 i, {r0, r1});
      end
      edge_wait();
      ea = (i == 3) ? 5'd20 : 5'(i + 1);
      n_chk++;
      if (we !== 1'b1 || wa !== ea) begin
        n_fail++;
        $display("FAIL guard_wa cyc=%0d we=%0b wa=%0d want 1/%0d",
                 i, we, wa, ea);
      end
      @(negedge clk);
    end
`else
    for (int i = 0; i < 20; i++) begin
      a0 = 5'(i + 1);
      d0 = 32'(i + 100);
      #1;
      n_chk++;
      if ({r0, r1} !== 2'b10) begin
        n_fail++;
        $display("FAIL starve cyc=%0d got %b want 10",
                 i, {r0, r1});
      end
      edge_wait();
      ea = 5'(i + 1);
      n_chk++;
      if ({we, wa, wn} !== {1'b1, ea, 32'(i + 100)}) begin
        n_fail++;
        $display("FAIL b2b cyc=%0d we=%0b wa=%0d wn=%h want 1/%0d",
                 i, we, wa, wn, ea);
      end
      @(negedge clk);
    end
`endif
    idle();
    edge_wait();
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    v0 = 1'b1;
    a0 = 5'd8;
    d0 = 32'h88;
    iss_valid = 1'b1;
    iss_addr = 5'd11;
    edge_wait();
    n_chk++;
    if (we !== 1'b1 || busy !== 32'h0000_0800) begin
      n_fail++;
      $display("FAIL mid_pre we=%0b busy=%h want 1/00000800",
               we, busy);
    end
    #1;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({we, wa, wn} !== 38'd0 || busy !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_rst we=%0b wa=%0d wn=%h busy=%h want 0",
               we, wa, wn, busy);
    end
    @(negedge clk);
    idle();
    rst = 1'b1;
    edge_wait();
    n_chk++;
    if (we !== 1'b0 || busy !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_post we=%0b busy=%h want 0/0", we, busy);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    idle();
    test_reset();
    test_single();
    test_priority();
    test_scoreboard();
    test_x0();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (wa/wn/we) between two write-back requesters: port 0 (ALU, high priority) and port 1 (load/store unit).
- Registers the granted write onto the write port one cycle after the handshake.
- Keeps a 32-bit pending-write scoreboard that decode uses to stall on RAW hazards.
- Sits between the EX/MEM write-back stages and the register file.

Parameters:
MAX_WAIT, 3, consecutive cycles port 1 may lose arbitration before it is force-granted (only with the optional feature).
CNT_W, 2, width of the starvation counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
v0  input  1  port 0 write request valid
a0  input  5  port 0 destination register
d0  input  32  port 0 write data
r0  output  1  port 0 accepted (combinational)
v1  input  1  port 1 write request valid
a1  input  5  port 1 destination register
d1  input  32  port 1 write data
r1  output  1  port 1 accepted (combinational)
iss_valid  input  1  decode issues an instruction with a destination register
iss_addr  input  5  destination of the issued instruction
busy  output  32  scoreboard; bit i = write to xi pending
we  output  1  register file write enable (registered)
wa  output  5  register file write address (registered)
wn  output  32  register file write data (registered)

Behaviour:
- Reset (rst=0, async): we=0, wa=0, wn=0, busy=0, starvation counter=0. Requests arriving during reset are ignored. Reset in the middle of a stream drops any in-flight transfer.
- Transfer on port k occurs when vk & rk are high at a rising edge.
- Arbitration, default (strict priority):
  - r0 = v0.
  - r1 = v1 & ~v0.
  - At most one of r0/r1 is high in any cycle.
- Requesters hold a, d and v stable until accepted. Ready is never withheld from an idle port.
- Latency: a transfer at edge N drives we=1, wa=ak, wn=dk in the cycle after edge N. we returns to 0 at edge N+1 unless another transfer occurs. Sustained throughput is 1 write/cycle.
- x0 writes: accepted normally, but we stays 0 and wa/wn keep their previous values.
- Scoreboard updates, at each rising edge:
  - iss_valid & iss_addr != 0 sets busy[iss_addr].
  - A transfer with ak != 0 clears busy[ak].
  - Set and clear to the same address in the same cycle: set wins, because a newer producer is pending.
  - Different addresses: both updates apply.
  - busy[0] is always 0.
- A transfer to a register whose busy bit is 0 is legal: the write happens and the bit stays 0.
- No internal state machine beyond the scoreboard and the counter. The block holds no data buffering.

Optional Feature:
WBARB_STARVE_GUARD_EN.
- Defined:
  - The counter increments at each edge where v1 & v0 & ~r1, saturating at MAX_WAIT.
  - The counter clears on a port 1 transfer or when v1=0.
  - When counter == MAX_WAIT: r1 = v1 and r0 = 0 for that cycle.
- Not defined: the counter is absent and arbitration is strict priority. Port 1 can starve indefinitely under continuous v0.

Test Plan:
- Reset, then release rst → we=0, wa=0, wn=0, busy=32'h0. r0=r1=0 while v0=v1=0.
- v0=1, a0=5, d0=32'hDEADBEEF for one cycle → r0=1 that cycle. Next cycle we=1, wa=5, wn=32'hDEADBEEF. Following cycle we=0.
- v0 and v1 both high: a0=3/d0=1, a1=4/d1=2 → r0=1, r1=0. Next cycle: write to x3 appears, then v0 drops and r1=1. x4 is written one cycle later.
- iss_valid with iss_addr=7, then a transfer with a1=7 two cycles later → busy[7]=1 for 2 cycles, then 0. Repeat with iss_addr=7 in the same cycle as the transfer → busy[7] stays 1.
- a0=0, d0=32'hFFFFFFFF accepted → we stays 0. iss_addr=0 leaves busy[0]=0.
- With WBARB_STARVE_GUARD_EN and MAX_WAIT=3: v0 and v1 held high continuously → r1=1 on the 4th cycle, r0=0 that cycle, and the counter is 0 afterwards. Without the macro, r1 stays 0 for 20 cycles.
